ap_ctrl_perf_monitor: RTL and testbench
=======================================

AP_CTRL_PERF_MONITOR -- requirements
Module: ap_ctrl_perf_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 21, number of monitored ap_ctrl channels (1..64).
REQ-002 SHALL have parameter CNT_W, default 32, event/cycle counter width (16..48).
REQ-003 SHALL have parameter LAT_W, default 24, latency register width (8..CNT_W).
REQ-004 SHALL have port clock  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ap_start  in  N_CH  per-channel start, bit i = channel i.
REQ-007 SHALL have port ap_ready  in  N_CH  per-channel ready pulse.
REQ-008 SHALL have port ap_done  in  N_CH  per-channel done.
REQ-009 SHALL have port ap_continue  in  N_CH  per-channel continue; tie 1 for non-dataflow channels.
REQ-010 SHALL have port finish  in  1  end-of-test; freezes all statistics.
REQ-011 SHALL have port clear  in  1  synchronous statistics clear.
REQ-012 SHALL have port rd_req  in  1  readout request.
REQ-013 SHALL have port rd_ch  in  $clog2(N_CH) (min 1)  channel select.
REQ-014 SHALL have port rd_field  in  3  field select: 0 start_cnt, 1 ready_cnt, 2 done_cnt, 3 busy_cyc, 4 stall_cyc, 5 last_lat, 6 min_lat, 7 max_lat.
REQ-015 SHALL have port rd_valid  out  1  readout data valid.
REQ-016 SHALL have port rd_data  out  CNT_W  readout value, latencies zero-extended.
REQ-017 SHALL have port overflow  out  N_CH  sticky per-channel saturation flag.
REQ-018 SHALL have port active  out  1  OR of all channels not IDLE.

Function
REQ-019 Each channel SHALL run FSM IDLE/RUN/DONE_WAIT.
REQ-020 IDLE->RUN when ap_start=1; lat counter loads 1; start_cnt+1.
REQ-021 RUN: lat+1 and busy_cyc+1 each cycle; ap_done=1 & ap_continue=1 -> IDLE; ap_done=1 & ap_continue=0 -> DONE_WAIT.
REQ-022 Done in the start cycle (IDLE with ap_start & ap_done) SHALL complete a latency-1 transaction, staying in IDLE if ap_continue=1.
REQ-023 On RUN exit: done_cnt+1, last_lat=lat, min_lat=min(min_lat,lat), max_lat=max(max_lat,lat).
REQ-024 DONE_WAIT: stall_cyc+1 per cycle; ->IDLE when ap_continue=1 (that cycle counted as stall).
REQ-025 ready_cnt SHALL increment on every cycle ap_ready=1, independent of FSM state.
REQ-026 All counters SHALL saturate at all-ones; any saturation sets overflow[i], held until reset/clear.
REQ-027 min_lat SHALL read all-ones until first completed transaction.
REQ-028 finish=1 SHALL set a sticky freeze: counters, latencies and FSMs hold; readout remains operational.
REQ-029 clear SHALL zero counters/latencies/overflow, set min_lat all-ones, FSMs to IDLE, release freeze; clear wins over same-cycle events.
REQ-030 Readout latency SHALL be 1 cycle: rd_valid=rd_req registered; rd_data = selected field value as of the rd_req cycle.
REQ-031 rd_ch >= N_CH SHALL return rd_data=0 with rd_valid=1.
REQ-032 Counter updates and readout in the same cycle SHALL return the pre-update value.

Reset
REQ-033 reset SHALL force: FSMs IDLE, all counters 0, min_lat all-ones, overflow 0, freeze 0, rd_valid 0, rd_data 0, active 0.
REQ-034 reset asserted mid-transaction SHALL abandon it without updating done_cnt or latencies.

Structure
REQ-035 Field encodings and FSM state enum SHALL reside in shared package ap_ctrl_perf_pkg.
REQ-036 Per-channel FSM and counters SHALL be sub-module ap_ctrl_chan_stats, instantiated N_CH times by generate; top holds freeze, clear fan-out, readout mux.

Verification
REQ-037 Ch0: start at cycle 10, done&continue at cycle 14 -> start_cnt=1, done_cnt=1, last/min/max_lat=5, busy_cyc=4.
REQ-038 Ch2: done at latency 3 with continue=0 for 4 cycles -> stall_cyc=4, FSM IDLE after, done_cnt=1.
REQ-039 Ch1: latencies 7, 2, 9 -> min_lat=2, max_lat=9, last_lat=9; fresh channel min_lat reads 0xFFFFFFFF.
REQ-040 CNT_W=16, ap_ready held 70000 cycles -> ready_cnt=0xFFFF, overflow[i]=1; clear -> 0, overflow 0.
REQ-041 finish mid-RUN then 50 more cycles -> busy_cyc unchanged; rd_ch=N_CH -> rd_valid=1, rd_data=0.
REQ-042 reset during RUN on ch3 -> done_cnt=0, min_lat all-ones, active=0 next cycle.

Source files
------------

// File: rtl/ap_ctrl_perf_pkg.sv
// Shared encodings for the ap_ctrl performance monitor: channel FSM states
// and readout field selectors.
package ap_ctrl_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_DONE_WAIT = 2'd2
  } chan_state_e;

  typedef enum logic [2:0] {
    FLD_START_CNT = 3'd0,
    FLD_READY_CNT = 3'd1,
    FLD_DONE_CNT  = 3'd2,
    FLD_BUSY_CYC  = 3'd3,
    FLD_STALL_CYC = 3'd4,
    FLD_LAST_LAT  = 3'd5,
    FLD_MIN_LAT   = 3'd6,
    FLD_MAX_LAT   = 3'd7
  } rd_field_e;

endpackage

// File: rtl/ap_ctrl_chan_stats.sv
// One monitored ap_ctrl channel: IDLE/RUN/DONE_WAIT tracker, saturating
// event/cycle counters, latency statistics and a sticky overflow flag.
// Latency counts cycles from the start cycle to the done cycle inclusive.
module ap_ctrl_chan_stats
  import ap_ctrl_perf_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int LAT_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic             start,
  input  logic             ready,
  input  logic             done,
  input  logic             cont,
  input  rd_field_e        field,
  output logic [CNT_W-1:0] value,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [LAT_W-1:0] L_ONE = LAT_W'(1);

  chan_state_e      state, state_nx;
  logic [CNT_W-1:0] start_cnt, ready_cnt, done_cnt, busy_cyc, stall_cyc;
  logic [LAT_W-1:0] lat, lat_nx, last_lat, min_lat, max_lat;
  logic             min_seen;
  logic             inc_start, inc_busy, inc_stall, complete, ovf_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + C_ONE;
  endfunction

  // State register; frozen while hold is set, cleared by reset or clear.
  always_ff @(posedge clock) begin
    if (reset || clear) state <= ST_IDLE;
    else if (!hold)     state <= state_nx;
  end

  // Next state plus per-cycle event strobes and the running latency.
  always_comb begin
    state_nx  = state;
    lat_nx    = lat;
    inc_start = 1'b0;
    inc_busy  = 1'b0;
    inc_stall = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        inc_start = 1'b1;
        lat_nx    = L_ONE;
        if (done) begin
          complete = 1'b1;
          state_nx = cont ? ST_IDLE : ST_DONE_WAIT;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        inc_busy = 1'b1;
        lat_nx   = (lat == '1) ? lat : lat + L_ONE;
        if (done) begin
          complete = 1'b1;
          state_nx = cont ? ST_IDLE : ST_DONE_WAIT;
        end
      end
      ST_DONE_WAIT: begin
        inc_stall = 1'b1;
        if (cont) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // An increment attempted on a counter already at all-ones is a lost event.
  assign ovf_hit = (ready     && ready_cnt == '1) ||
                   (inc_start && start_cnt == '1) ||
                   (complete  && done_cnt  == '1) ||
                   (inc_busy  && busy_cyc  == '1) ||
                   (inc_stall && stall_cyc == '1) ||
                   (inc_busy  && lat       == '1);

  // Statistics update; everything holds while frozen.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      start_cnt <= '0;
      ready_cnt <= '0;
      done_cnt  <= '0;
      busy_cyc  <= '0;
      stall_cyc <= '0;
      lat       <= '0;
      last_lat  <= '0;
      min_lat   <= '1;
      max_lat   <= '0;
      min_seen  <= 1'b0;
      overflow  <= 1'b0;
    end else if (!hold) begin
      if (inc_start) start_cnt <= sat_inc(start_cnt);
      if (ready)     ready_cnt <= sat_inc(ready_cnt);
      if (complete)  done_cnt  <= sat_inc(done_cnt);
      if (inc_busy)  busy_cyc  <= sat_inc(busy_cyc);
      if (inc_stall) stall_cyc <= sat_inc(stall_cyc);
      lat <= lat_nx;
      if (complete) begin
        last_lat <= lat_nx;
        min_seen <= 1'b1;
        if (!min_seen || lat_nx < min_lat) min_lat <= lat_nx;
        if (lat_nx > max_lat)               max_lat <= lat_nx;
      end
      overflow <= overflow | ovf_hit;
    end
  end

  // Field select; min_lat reads full-width all-ones until a transaction completes.
  always_comb begin
    value = '0;
    case (field)
      FLD_START_CNT: value = start_cnt;
      FLD_READY_CNT: value = ready_cnt;
      FLD_DONE_CNT:  value = done_cnt;
      FLD_BUSY_CYC:  value = busy_cyc;
      FLD_STALL_CYC: value = stall_cyc;
      FLD_LAST_LAT:  value = CNT_W'(last_lat);
      FLD_MIN_LAT:   value = min_seen ? CNT_W'(min_lat) : '1;
      FLD_MAX_LAT:   value = CNT_W'(max_lat);
      default:       value = '0;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Performance monitor for N_CH ap_ctrl channels: per-channel stats blocks,
// sticky freeze on finish, clear fan-out and a registered readout mux.
module ap_ctrl_perf_monitor
  import ap_ctrl_perf_pkg::*;
#(
  parameter  int N_CH  = 21,
  parameter  int CNT_W = 32,
  parameter  int LAT_W = 24,
  localparam int RD_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_CH-1:0]  ap_start,
  input  logic [N_CH-1:0]  ap_ready,
  input  logic [N_CH-1:0]  ap_done,
  input  logic [N_CH-1:0]  ap_continue,
  input  logic             finish,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [RD_W-1:0]  rd_ch,
  input  logic [2:0]       rd_field,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic [N_CH-1:0]  overflow,
  output logic             active
);

  logic                        freeze;
  logic                        hold;
  logic [N_CH-1:0][CNT_W-1:0]  field_val;
  logic [N_CH-1:0]             busy_vec;

  // Sticky freeze set by finish, released only by clear or reset.
  always_ff @(posedge clock) begin
    if (reset || clear) freeze <= 1'b0;
    else if (finish)    freeze <= 1'b1;
  end

  // The finish cycle itself already holds the statistics.
  assign hold = freeze | finish;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ap_ctrl_chan_stats #(.CNT_W(CNT_W), .LAT_W(LAT_W)) u_stats (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .hold     (hold),
      .start    (ap_start[i]),
      .ready    (ap_ready[i]),
      .done     (ap_done[i]),
      .cont     (ap_continue[i]),
      .field    (rd_field_e'(rd_field)),
      .value    (field_val[i]),
      .overflow (overflow[i]),
      .busy     (busy_vec[i])
    );
  end

  // Readout samples pre-update values; out-of-range channels read zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= (int'(rd_ch) < N_CH) ? field_val[rd_ch] : '0;
    end
  end

  assign active = |busy_vec;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the channel statistics.
module tb_ap_ctrl_perf_monitor;

  localparam int     NCH  = 21;
  localparam longint CMAX = 64'hFFFF_FFFF;
  localparam longint LMAX = 64'h00FF_FFFF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset, finish, clear, rd_req;
  logic [NCH-1:0]  ap_start, ap_ready, ap_done, ap_continue;
  logic [4:0]      rd_ch;
  logic [2:0]      rd_field;
  logic            rd_valid;
  logic [31:0]     rd_data;
  logic [NCH-1:0]  overflow;
  logic            active;

  logic            clear2, rd_req2;
  logic [1:0]      ready2;
  logic [0:0]      rd_ch2;
  logic [2:0]      rd_field2;
  logic            rd_valid2, active2;
  logic [15:0]     rd_data2;
  logic [1:0]      ovf2;

  ap_ctrl_perf_monitor dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clear(clear),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_field(rd_field), .rd_valid(rd_valid),
    .rd_data(rd_data), .overflow(overflow), .active(active)
  );

  ap_ctrl_perf_monitor #(.N_CH(2), .CNT_W(16), .LAT_W(12)) dut16 (
    .clock(clock), .reset(reset), .ap_start(2'b00), .ap_ready(ready2),
    .ap_done(2'b00), .ap_continue(2'b11), .finish(1'b0), .clear(clear2),
    .rd_req(rd_req2), .rd_ch(rd_ch2), .rd_field(rd_field2), .rd_valid(rd_valid2),
    .rd_data(rd_data2), .overflow(ovf2), .active(active2)
  );

  int errs = 0, checks = 0;

  // ---- behavioural model: counters 0..4 follow field numbering ----
  longint         cnt [NCH][5];
  longint         last_l [NCH], min_l [NCH], max_l [NCH], st [NCH];
  bit             seen [NCH];
  int             ph [NCH];  // 0 idle, 1 running, 2 waiting for continue
  bit [NCH-1:0]   movf;
  bit             mfrz;
  longint         mcyc;
  longint         exp_rd;
  bit             pend;

  function automatic void m_init();
    for (int c = 0; c < NCH; c++) begin
      for (int f = 0; f < 5; f++) cnt[c][f] = 0;
      last_l[c] = 0; min_l[c] = 0; max_l[c] = 0; st[c] = 0;
      seen[c] = 0; ph[c] = 0;
    end
    movf = '0; mfrz = 0; mcyc = 0;
  endfunction

  function automatic void bump(int c, int f);
    if (cnt[c][f] == CMAX) movf[c] = 1'b1;
    else cnt[c][f]++;
  endfunction

  function automatic void txn_done(int c, longint l);
    bump(c, 2);
    last_l[c] = l;
    if (!seen[c] || l < min_l[c]) min_l[c] = l;
    if (l > max_l[c]) max_l[c] = l;
    seen[c] = 1;
  endfunction

  function automatic void m_cycle();
    longint l;
    if (reset || clear) begin m_init(); return; end
    if (mfrz || finish) begin mfrz = 1; return; end
    for (int c = 0; c < NCH; c++) begin
      if (ap_ready[c]) bump(c, 1);
      case (ph[c])
        0: if (ap_start[c]) begin
          bump(c, 0);
          st[c] = mcyc;
          if (ap_done[c]) begin txn_done(c, 1); ph[c] = ap_continue[c] ? 0 : 2; end
          else ph[c] = 1;
        end
        1: begin
          bump(c, 3);
          l = mcyc - st[c] + 1;
          if (l > LMAX) begin movf[c] = 1'b1; l = LMAX; end
          if (ap_done[c]) begin txn_done(c, l); ph[c] = ap_continue[c] ? 0 : 2; end
        end
        default: begin
          bump(c, 4);
          if (ap_continue[c]) ph[c] = 0;
        end
      endcase
    end
    mcyc++;
  endfunction

  function automatic longint exp_field(int c, int f);
    if (c >= NCH) return 0;
    if (f < 5)  return cnt[c][f];
    if (f == 5) return last_l[c];
    if (f == 6) return seen[c] ? min_l[c] : 64'hFFFF_FFFF;
    return max_l[c];
  endfunction

  function automatic bit m_active();
    for (int c = 0; c < NCH; c++) if (ph[c] != 0) return 1;
    return 0;
  endfunction

  // One clock of the main DUT; expected readout captured before the update.
  task automatic step();
    pend = rd_req;
    if (rd_req) exp_rd = exp_field(int'(rd_ch), int'(rd_field));
    m_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(int c, int f);
    rd_req = 1'b1; rd_ch = 5'(c); rd_field = 3'(f);
    step();
    rd_req = 1'b0;
  endtask

  task automatic run_txn(int c, int len);
    ap_start[c] = 1'b1;
    if (len == 1) ap_done[c] = 1'b1;
    step();
    ap_start[c] = 1'b0; ap_done[c] = 1'b0;
    for (int i = 2; i <= len; i++) begin
      if (i == len) ap_done[c] = 1'b1;
      step();
      ap_done[c] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (rd_valid !== 1'b0 || rd_data !== 32'd0 || active !== 1'b0 || overflow !== '0) begin
      errs++; $display("FAIL reset_outputs got v=%b d=%h act=%b ovf=%h want all zero", rd_valid, rd_data, active, overflow);
    end
    reset = 1'b0;
    rd(0, 0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
      errs++; $display("FAIL reset_start_cnt got v=%b d=%h want v=1 d=0", rd_valid, rd_data);
    end
    rd(0, 6);
    checks++; if (rd_data !== 32'hFFFF_FFFF) begin
      errs++; $display("FAIL reset_min_lat got %h want ffffffff", rd_data);
    end
  endtask

  task automatic test_single();
    int     f_tab [6] = '{0, 2, 3, 5, 6, 7};
    longint v_tab [6] = '{1, 1, 4, 5, 5, 5};
    run_txn(0, 5);
    for (int i = 0; i < 6; i++) begin
      rd(0, f_tab[i]);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 32'(v_tab[i])) begin
        errs++; $display("FAIL single_field%0d got v=%b d=%0d want %0d", f_tab[i], rd_valid, rd_data, v_tab[i]);
      end
    end
  endtask

  task automatic test_stall();
    ap_start[2] = 1'b1; step(); ap_start[2] = 1'b0;
    step();
    ap_done[2] = 1'b1; ap_continue[2] = 1'b0; step(); ap_done[2] = 1'b0;
    repeat (3) step();
    checks++; if (active !== 1'b1) begin
      errs++; $display("FAIL stall_active_wait got %b want 1", active);
    end
    ap_continue[2] = 1'b1; step();
    checks++; if (active !== 1'b0) begin
      errs++; $display("FAIL stall_idle_after got active=%b want 0", active);
    end
    rd(2, 4);
    checks++; if (rd_data !== 32'd4) begin errs++; $display("FAIL stall_cyc got %0d want 4", rd_data); end
    rd(2, 2);
    checks++; if (rd_data !== 32'd1) begin errs++; $display("FAIL stall_done_cnt got %0d want 1", rd_data); end
    rd(2, 5);
    checks++; if (rd_data !== 32'd3) begin errs++; $display("FAIL stall_last_lat got %0d want 3", rd_data); end
  endtask

  task automatic test_minmax();
    run_txn(1, 7); run_txn(1, 2); run_txn(1, 9);
    rd(1, 6);
    checks++; if (rd_data !== 32'd2) begin errs++; $display("FAIL minmax_min got %0d want 2", rd_data); end
    rd(1, 7);
    checks++; if (rd_data !== 32'd9) begin errs++; $display("FAIL minmax_max got %0d want 9", rd_data); end
    rd(1, 5);
    checks++; if (rd_data !== 32'd9) begin errs++; $display("FAIL minmax_last got %0d want 9", rd_data); end
    rd(1, 2);
    checks++; if (rd_data !== 32'd3) begin errs++; $display("FAIL minmax_done_cnt got %0d want 3", rd_data); end
    rd(5, 6);
    checks++; if (rd_data !== 32'hFFFF_FFFF) begin errs++; $display("FAIL fresh_min got %h want ffffffff", rd_data); end
  endtask

  task automatic test_freeze();
    ap_start[4] = 1'b1; step(); ap_start[4] = 1'b0;
    repeat (3) step();
    finish = 1'b1; step(); finish = 1'b0;
    ap_ready[4] = 1'b1;
    repeat (50) step();
    ap_ready[4] = 1'b0;
    rd(4, 3);
    checks++; if (rd_data !== 32'd3) begin errs++; $display("FAIL freeze_busy got %0d want 3", rd_data); end
    rd(4, 1);
    checks++; if (rd_data !== 32'd0) begin errs++; $display("FAIL freeze_ready got %0d want 0", rd_data); end
    checks++; if (active !== 1'b1) begin errs++; $display("FAIL freeze_active got %b want 1", active); end
    rd(NCH, 3);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
      errs++; $display("FAIL bad_ch got v=%b d=%h want v=1 d=0", rd_valid, rd_data);
    end
    clear = 1'b1; step(); clear = 1'b0;
    rd(4, 3);
    checks++; if (rd_data !== 32'd0 || active !== 1'b0) begin
      errs++; $display("FAIL clear_after_freeze got busy=%0d act=%b want 0 0", rd_data, active);
    end
  endtask

  task automatic test_reset_midrun();
    ap_start[3] = 1'b1; step(); ap_start[3] = 1'b0;
    repeat (2) step();
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (active !== 1'b0) begin errs++; $display("FAIL midrun_active got %b want 0", active); end
    rd(3, 2);
    checks++; if (rd_data !== 32'd0) begin errs++; $display("FAIL midrun_done_cnt got %0d want 0", rd_data); end
    rd(3, 6);
    checks++; if (rd_data !== 32'hFFFF_FFFF) begin errs++; $display("FAIL midrun_min got %h want ffffffff", rd_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2500; n++) begin
      ap_start    = NCH'($urandom & $urandom);
      ap_done     = NCH'($urandom & $urandom);
      ap_continue = ~NCH'($urandom & $urandom);
      ap_ready    = NCH'($urandom & $urandom);
      finish      = ($urandom_range(0, 599) == 0);
      clear       = ($urandom_range(0, 249) == 0);
      rd_req      = ($urandom_range(0, 3) != 0);
      rd_ch       = 5'($urandom_range(0, 23));
      rd_field    = 3'($urandom_range(0, 7));
      step();
      checks++;
      if (pend && (rd_valid !== 1'b1 || rd_data !== 32'(exp_rd))) begin
        errs++; $display("FAIL rand_read n=%0d ch=%0d f=%0d got v=%b d=%h want %h", n, rd_ch, rd_field, rd_valid, rd_data, 32'(exp_rd));
      end else if (!pend && rd_valid !== 1'b0) begin
        errs++; $display("FAIL rand_valid n=%0d got %b want 0", n, rd_valid);
      end
      checks++; if (overflow !== movf || active !== m_active()) begin
        errs++; $display("FAIL rand_status n=%0d got ovf=%h act=%b want ovf=%h act=%b", n, overflow, active, movf, m_active());
      end
    end
    ap_start = '0; ap_done = '0; ap_ready = '0; ap_continue = '1;
    finish = 1'b0; clear = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_overflow16();
    ready2 = 2'b01;
    repeat (70000) @(posedge clock);
    #1; ready2 = 2'b00;
    rd_req2 = 1'b1; rd_ch2 = 1'b0; rd_field2 = 3'd1;
    @(posedge clock); #1; rd_req2 = 1'b0;
    checks++; if (rd_valid2 !== 1'b1 || rd_data2 !== 16'hFFFF) begin
      errs++; $display("FAIL sat_ready got v=%b d=%h want v=1 d=ffff", rd_valid2, rd_data2);
    end
    checks++; if (ovf2 !== 2'b01) begin errs++; $display("FAIL sat_overflow got %b want 01", ovf2); end
    clear2 = 1'b1; @(posedge clock); #1; clear2 = 1'b0;
    checks++; if (ovf2 !== 2'b00) begin errs++; $display("FAIL sat_clear_ovf got %b want 00", ovf2); end
    rd_req2 = 1'b1; @(posedge clock); #1; rd_req2 = 1'b0;
    checks++; if (rd_data2 !== 16'd0) begin errs++; $display("FAIL sat_clear_cnt got %h want 0", rd_data2); end
  endtask

  initial begin
    reset = 1'b1; finish = 1'b0; clear = 1'b0; rd_req = 1'b0; rd_ch = '0; rd_field = '0;
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    clear2 = 1'b0; rd_req2 = 1'b0; ready2 = '0; rd_ch2 = '0; rd_field2 = '0;
    m_init();
    test_reset();
    test_single();
    test_stall();
    test_minmax();
    test_freeze();
    test_reset_midrun();
    test_random();
    test_overflow16();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
